bw_r_irf_win_bank: RTL and testbench
====================================

Name: bw_r_irf_win_bank

Overview:
Parametrised, multi-thread successor to the single-register window cell in the integer register file. It holds one active register per thread plus a backing window store of NWIN entries per thread. It performs save, restore and combined swap (save then restore) operations under a busy handshake. It sits in the sparc_core IRF datapath, one instance per architectural register slot, and is driven by the window-management control (SAVE/RESTORE/trap) logic.

Parameters:
DW, 72, data width per register (64 data + 8 ECC, opaque to this block)
NWIN, 8, windows per thread
AW, 3, window address width (log2 NWIN)
NTHR, 4, hardware threads
TW, 2, thread-id width (log2 NTHR)

Ports:
clk  input  1  core clock, all state on posedge
reset  input  1  synchronous active-high reset
wr_en  input  1  write active register
wr_tid  input  TW  thread for write
wr_data  input  DW  write data
rd_tid  input  TW  thread selector for read
rd_data  output  DW  active register of rd_tid (combinational mux of flops)
save_req  input  1  request save of active reg to window
save_tid  input  TW  thread for save
save_addr  input  AW  destination window
restore_req  input  1  request restore from window to active reg
restore_tid  input  TW  thread for restore (must equal save_tid when both asserted)
restore_addr  input  AW  source window
busy  output  1  operation in progress; new requests not accepted
req_drop  output  1  one-cycle pulse: a request arrived while busy and was ignored

Behaviour:
- Reset: all active regs <= 0, state IDLE, busy=0, req_drop=0, rd_data=0. Window store is not reset (RAM). Reset asserted mid-operation aborts it; no window or active write occurs on or after the reset edge.
- Request accepted in cycle T iff (save_req|restore_req) & !busy & !reset. Accepted tid/addr latched at end of T.
- Snapshot rule: a save captures the active value as updated by cycle T, i.e. wr_data if wr_en & wr_tid==save_tid in T, else active[save_tid].
- FSM: IDLE, SAVE, RST, SWAP_W, SWAP_R.
  IDLE -> SAVE (save only), -> RST (restore only), -> SWAP_W (both).
  SAVE (T+1): window[tid][addr] <= snapshot at end of T+1; -> IDLE.
  RST (T+1): window read; active[tid] <= window[tid][addr] at end of T+1; -> IDLE.
  SWAP_W (T+1): window write as in SAVE; -> SWAP_R.
  SWAP_R (T+2): active[tid] <= window[tid][restore_addr]; if restore_addr==save_addr the forwarded snapshot is used; -> IDLE.
- busy=1 exactly in SAVE, RST, SWAP_W and SWAP_R (1 cycle for save/restore, 2 for swap). busy is registered, state-decoded.
- req_drop=1 in cycle T+1 when a request was present in T with busy=1 in T. Dropped requests have no side effect.
- Write collisions: wr_en is always accepted. If a restore load targets the same tid in the same cycle, the restore wins and wr_data is lost. A different tid writes normally. A wr_en to the saving tid during SAVE/SWAP_W does not alter the stored snapshot.
- save_tid!=restore_tid with both requested is illegal: the block treats it as a swap on save_tid. Verification checks this with an assertion only.
- rd_data reflects active-reg updates on the cycle after the edge (no same-cycle bypass of wr_data).

Decomposition:
- Shared package bw_irf_pkg: state encoding constants (IDLE=0, SAVE=1, RST=2, SWAP_W=3, SWAP_R=4), default DW/NWIN/NTHR values.
- Sub-module bw_r_irf_win_store: NTHR*NWIN x DW synchronous single-port RAM. It takes an index {tid,addr}, write enable and data, and provides a registered-address read. This keeps it mappable to block RAM.
- The FSM, snapshot register and active-reg array stay in the top module.

Test Plan:
- Reset then rd_tid=0..3 -> rd_data=0 for all threads; busy=0.
- Write tid1=0xAA.., save_req tid1 addr5 at T; then write tid1=0x55.., restore addr5 at T+3 -> busy high T+1 only per op; rd_data(tid1)=0xAA.. from T+5.
- Same-cycle wr_en tid2=0x1234 with save_req tid2 addr0, then restore addr0 -> restored value 0x1234 (snapshot forwarding).
- Swap tid3 save addr2 / restore addr6 (window6 preloaded 0xBEEF) -> busy T+1..T+2, window2=old active, active=0xBEEF after T+2. Repeat with addr2/addr2 -> active unchanged value.
- save_req during busy -> req_drop pulses next cycle; window contents unchanged; restore with concurrent wr_en same tid -> restore data wins.
- Assert reset during SWAP_W -> state IDLE, no active/window update, busy=0 next cycle.

Source files
------------

// File: rtl/bw_irf_pkg.sv
// Shared definitions for the windowed IRF bank: FSM state encoding and default sizes.
package bw_irf_pkg;

  localparam int DW_DEF   = 72;
  localparam int NWIN_DEF = 8;
  localparam int AW_DEF   = 3;
  localparam int NTHR_DEF = 4;
  localparam int TW_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAVE   = 3'd1,
    ST_RST    = 3'd2,
    ST_SWAP_W = 3'd3,
    ST_SWAP_R = 3'd4
  } state_e;

endpackage : bw_irf_pkg

// File: rtl/bw_r_irf_win_store.sv
// Backing window store: single-port synchronous RAM with a registered read.
// The read register holds its value on write cycles. The swap sequence relies on this,
// because it reads the restore window one cycle before the save write.
module bw_r_irf_win_store #(
  parameter int DW    = 72,
  parameter int IW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write or read one entry per cycle; the read data is registered.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end else begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule : bw_r_irf_win_store

// File: rtl/bw_r_irf_win_bank.sv
// Per-thread active register plus window store.
// Provides save, restore and swap under a busy handshake.
module bw_r_irf_win_bank
  import bw_irf_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NWIN = NWIN_DEF,
  parameter int AW   = AW_DEF,
  parameter int NTHR = NTHR_DEF,
  parameter int TW   = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_tid,
  input  logic [DW-1:0] wr_data,
  input  logic [TW-1:0] rd_tid,
  output logic [DW-1:0] rd_data,
  input  logic          save_req,
  input  logic [TW-1:0] save_tid,
  input  logic [AW-1:0] save_addr,
  input  logic          restore_req,
  input  logic [TW-1:0] restore_tid,
  input  logic [AW-1:0] restore_addr,
  output logic          busy,
  output logic          req_drop
);

  localparam int IW    = TW + AW;
  localparam int DEPTH = NTHR * NWIN;

  state_e        state_q, state_d;
  logic [TW-1:0] tid_q, tid_d;
  logic [AW-1:0] sav_addr_q, sav_addr_d;
  logic [AW-1:0] rst_addr_q, rst_addr_d;
  logic [DW-1:0] snap_q, snap_d;
  logic          req_drop_q, req_drop_d;
  logic [DW-1:0] active_q [NTHR];
  logic [DW-1:0] active_d [NTHR];

  logic          req_any;
  logic          accept;
  logic [TW-1:0] req_tid;
  logic [DW-1:0] snapshot;
  logic          ram_we;
  logic [IW-1:0] ram_idx;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          load_en;
  logic [DW-1:0] load_data;

  assign busy     = (state_q != ST_IDLE);
  assign req_drop = req_drop_q;
  assign rd_data  = active_q[rd_tid];
  assign req_any  = save_req | restore_req;
  assign accept   = req_any & ~busy;
  // A mismatched swap request is handled as a swap on save_tid.
  assign req_tid  = save_req ? save_tid : restore_tid;
  // The save value includes a same-cycle write to the saving thread.
  assign snapshot = (wr_en && (wr_tid == save_tid)) ? wr_data : active_q[save_tid];

  // Next-state logic, request latching and window RAM port control.
  always_comb begin
    state_d    = state_q;
    tid_d      = tid_q;
    sav_addr_d = sav_addr_q;
    rst_addr_d = rst_addr_q;
    snap_d     = snap_q;
    ram_we     = 1'b0;
    ram_idx    = {tid_q, rst_addr_q};
    ram_wdata  = snap_q;
    load_en    = 1'b0;
    load_data  = ram_rdata;
    req_drop_d = req_any & busy;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tid_d      = req_tid;
          sav_addr_d = save_addr;
          rst_addr_d = restore_addr;
          snap_d     = snapshot;
          // Start the restore read now so the data is registered for the load cycle.
          ram_idx    = {req_tid, restore_addr};
          if (save_req && restore_req) begin
            state_d = ST_SWAP_W;
          end else if (save_req) begin
            state_d = ST_SAVE;
          end else begin
            state_d = ST_RST;
          end
        end
      end
      ST_SAVE: begin
        ram_we  = 1'b1;
        ram_idx = {tid_q, sav_addr_q};
        state_d = ST_IDLE;
      end
      ST_RST: begin
        load_en = 1'b1;
        state_d = ST_IDLE;
      end
      ST_SWAP_W: begin
        ram_we  = 1'b1;
        ram_idx = {tid_q, sav_addr_q};
        state_d = ST_SWAP_R;
      end
      ST_SWAP_R: begin
        load_en = 1'b1;
        // The RAM read predates the save write, so forward the snapshot on an address match.
        if (rst_addr_q == sav_addr_q) begin
          load_data = snap_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Active register update: a restore load beats a direct write to the same thread.
  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      active_d[i] = active_q[i];
      if (load_en && (tid_q == TW'(i))) begin
        active_d[i] = load_data;
      end else if (wr_en && (wr_tid == TW'(i))) begin
        active_d[i] = wr_data;
      end
    end
  end

  // State, request context and active registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tid_q      <= '0;
      sav_addr_q <= '0;
      rst_addr_q <= '0;
      snap_q     <= '0;
      req_drop_q <= 1'b0;
      for (int i = 0; i < NTHR; i++) begin
        active_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tid_q      <= tid_d;
      sav_addr_q <= sav_addr_d;
      rst_addr_q <= rst_addr_d;
      snap_q     <= snap_d;
      req_drop_q <= req_drop_d;
      for (int i = 0; i < NTHR; i++) begin
        active_q[i] <= active_d[i];
      end
    end
  end

  bw_r_irf_win_store #(
    .DW    (DW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .we    (ram_we & ~reset),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule : bw_r_irf_win_bank

// File: tb/tb_bw_r_irf_win_bank.sv
// Directed bench for bw_r_irf_win_bank with an expected-value queue for read checks.
module tb_bw_r_irf_win_bank;

  localparam int DW = 72;
  localparam int AW = 3;
  localparam int TW = 2;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [TW-1:0] wr_tid;
  logic [DW-1:0] wr_data;
  logic [TW-1:0] rd_tid;
  logic [DW-1:0] rd_data;
  logic          save_req;
  logic [TW-1:0] save_tid;
  logic [AW-1:0] save_addr;
  logic          restore_req;
  logic [TW-1:0] restore_tid;
  logic [AW-1:0] restore_addr;
  logic          busy;
  logic          req_drop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [TW-1:0] tid;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb[$];

  localparam logic [DW-1:0] V_AA   = {9{8'hAA}};
  localparam logic [DW-1:0] V_55   = {9{8'h55}};
  localparam logic [DW-1:0] V_1234 = 72'h1234;
  localparam logic [DW-1:0] V_9999 = 72'h9999;
  localparam logic [DW-1:0] V_BEEF = 72'hBEEF;
  localparam logic [DW-1:0] V_CAFE = 72'hCAFE;
  localparam logic [DW-1:0] V_7777 = 72'h7777;
  localparam logic [DW-1:0] V_5A5A = 72'h5A5A;

  bw_r_irf_win_bank dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_tid       (wr_tid),
    .wr_data      (wr_data),
    .rd_tid       (rd_tid),
    .rd_data      (rd_data),
    .save_req     (save_req),
    .save_tid     (save_tid),
    .save_addr    (save_addr),
    .restore_req  (restore_req),
    .restore_tid  (restore_tid),
    .restore_addr (restore_addr),
    .busy         (busy),
    .req_drop     (req_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both requests together must name the same thread.
  always @(posedge clk) begin
    if (save_req && restore_req) begin
      checks++;
      assert (save_tid === restore_tid)
      else begin
        errors++;
        $error("FAIL illegal_tid observed=%0d expected=%0d", restore_tid, save_tid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string tag, input logic [TW-1:0] tid, input logic [DW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.tid = tid;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      rd_tid = e.tid;
      #1;
      assert (rd_data === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, rd_data, e.val);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [TW-1:0] tid, input logic [DW-1:0] val);
    wr_en   = 1'b1;
    wr_tid  = tid;
    wr_data = val;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_req(input logic sv, input logic rs, input logic [TW-1:0] tid,
                         input logic [AW-1:0] sa, input logic [AW-1:0] ra);
    save_req     = sv;
    restore_req  = rs;
    save_tid     = tid;
    restore_tid  = tid;
    save_addr    = sa;
    restore_addr = ra;
  endtask

  task automatic clr_req();
    save_req    = 1'b0;
    restore_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_tid = '0; wr_data = '0; rd_tid = '0;
    set_req(1'b0, 1'b0, 2'd0, 3'd0, 3'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    for (int t = 0; t < 4; t++) begin
      expect_rd("rst_rd", TW'(t), '0);
      check_rd();
    end
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_drop", req_drop, 1'b0);

    // Save then restore on thread 1
    do_write(2'd1, V_AA);
    set_req(1'b1, 1'b0, 2'd1, 3'd5, 3'd0);
    tick(); clr_req();
    check_bit("save_busy", busy, 1'b1);
    tick();
    check_bit("save_done", busy, 1'b0);
    do_write(2'd1, V_55);
    expect_rd("wr_t1", 2'd1, V_55); check_rd();
    set_req(1'b0, 1'b1, 2'd1, 3'd0, 3'd5);
    tick(); clr_req();
    check_bit("rst_op_busy", busy, 1'b1);
    expect_rd("rst_pre_load", 2'd1, V_55); check_rd();
    tick();
    check_bit("rst_op_done", busy, 1'b0);
    expect_rd("restore_t1", 2'd1, V_AA); check_rd();

    // Snapshot forwarding and immunity to writes during SAVE
    wr_en = 1'b1; wr_tid = 2'd2; wr_data = V_1234;
    set_req(1'b1, 1'b0, 2'd2, 3'd0, 3'd0);
    tick(); clr_req();
    wr_data = V_9999;
    tick(); wr_en = 1'b0;
    expect_rd("wr_during_save", 2'd2, V_9999); check_rd();
    set_req(1'b0, 1'b1, 2'd2, 3'd0, 3'd0);
    tick(); clr_req();
    tick();
    expect_rd("snapshot_fwd", 2'd2, V_1234); check_rd();

    // Swap with distinct addresses
    do_write(2'd3, V_BEEF);
    set_req(1'b1, 1'b0, 2'd3, 3'd6, 3'd0);
    tick(); clr_req();
    tick();
    do_write(2'd3, V_CAFE);
    set_req(1'b1, 1'b1, 2'd3, 3'd2, 3'd6);
    tick(); clr_req();
    check_bit("swap_w_busy", busy, 1'b1);
    tick();
    check_bit("swap_r_busy", busy, 1'b1);
    expect_rd("swap_pre_load", 2'd3, V_CAFE); check_rd();
    tick();
    check_bit("swap_done", busy, 1'b0);
    expect_rd("swap_load", 2'd3, V_BEEF); check_rd();
    set_req(1'b0, 1'b1, 2'd3, 3'd0, 3'd2);
    tick(); clr_req();
    tick();
    expect_rd("swap_win2", 2'd3, V_CAFE); check_rd();

    // Swap with the same address must return the new snapshot
    do_write(2'd3, V_7777);
    set_req(1'b1, 1'b1, 2'd3, 3'd2, 3'd2);
    tick(); clr_req();
    tick();
    tick();
    check_bit("swap_same_done", busy, 1'b0);
    expect_rd("swap_same_addr", 2'd3, V_7777); check_rd();

    // Request while busy is dropped; restore beats a same-thread write
    do_write(2'd0, 72'h11);
    set_req(1'b1, 1'b0, 2'd0, 3'd1, 3'd0);
    tick();
    check_bit("drop_busy", busy, 1'b1);
    wr_en = 1'b1; wr_tid = 2'd0; wr_data = 72'h22;
    tick(); clr_req(); wr_en = 1'b0;
    check_bit("req_drop_pulse", req_drop, 1'b1);
    check_bit("drop_no_start", busy, 1'b0);
    expect_rd("drop_wr", 2'd0, 72'h22); check_rd();
    tick();
    check_bit("req_drop_clear", req_drop, 1'b0);
    set_req(1'b0, 1'b1, 2'd0, 3'd0, 3'd1);
    tick(); clr_req();
    wr_en = 1'b1; wr_tid = 2'd0; wr_data = 72'h33;
    tick(); wr_en = 1'b0;
    expect_rd("restore_wins", 2'd0, 72'h11); check_rd();
    set_req(1'b0, 1'b1, 2'd0, 3'd0, 3'd1);
    tick(); clr_req();
    wr_en = 1'b1; wr_tid = 2'd1; wr_data = 72'h44;
    tick(); wr_en = 1'b0;
    expect_rd("other_tid_wr", 2'd1, 72'h44); check_rd();
    expect_rd("other_tid_restore", 2'd0, 72'h11); check_rd();

    // Reset during SWAP_W aborts the swap
    do_write(2'd3, V_5A5A);
    set_req(1'b1, 1'b1, 2'd3, 3'd6, 3'd2);
    tick(); clr_req();
    check_bit("abort_in_swap", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    expect_rd("abort_active", 2'd3, '0); check_rd();
    tick();
    check_bit("abort_no_swap_r", busy, 1'b0);
    expect_rd("abort_no_load", 2'd3, '0); check_rd();
    set_req(1'b0, 1'b1, 2'd3, 3'd0, 3'd6);
    tick(); clr_req();
    tick();
    expect_rd("abort_win6_intact", 2'd3, V_BEEF); check_rd();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bw_r_irf_win_bank
